// File: rtl/wb_write_buffer_if.sv
// rtl/wb_write_buffer_if.sv - producer requests and register-file write port of the writeback buffer
interface wb_write_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_valid;
  logic [4:0]    mem_wsel;
  logic [31:0]   mem_wdat;
  logic          mem_ready;
  logic          alu_valid;
  logic [4:0]    alu_wsel;
  logic [31:0]   alu_wdat;
  logic          alu_ready;
  logic          WEN;
  logic [4:0]    wsel;
  logic [31:0]   wdat;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  modport slave (
    input  mem_valid, mem_wsel, mem_wdat, alu_valid, alu_wsel, alu_wdat,
    output mem_ready, alu_ready, WEN, wsel, wdat, pending, count
  );

  modport master (
    output mem_valid, mem_wsel, mem_wdat, alu_valid, alu_wsel, alu_wdat,
    input  mem_ready, alu_ready, WEN, wsel, wdat, pending, count
  );
endinterface

// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - two-producer in-order writeback FIFO driving the register file write port
module wb_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  wb_write_buffer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    ent_wsel_q [DEPTH];
  logic [4:0]    ent_wsel_d [DEPTH];
  logic [31:0]   ent_wdat_q [DEPTH];
  logic [31:0]   ent_wdat_d [DEPTH];
  logic          wen_q, wen_d;
  logic [4:0]    wsel_q, wsel_d;
  logic [31:0]   wdat_q, wdat_d;

  logic          mem_ready, alu_ready;
  logic          mem_push, alu_push, pop;
  logic [AW-1:0] alu_slot;
  logic [AW-1:0] occ;
  logic [31:0]   pend;

  // Readiness looks only at the registered count so valid never feeds ready.
  assign mem_ready = (count_q <= CW'(DEPTH - 1));
  assign alu_ready = (count_q <= CW'(DEPTH - 2));

  // Writes to r0 complete the handshake but are dropped here.
  assign mem_push = bus.mem_valid && mem_ready && (bus.mem_wsel != 5'd0);
  assign alu_push = bus.alu_valid && alu_ready && (bus.alu_wsel != 5'd0);
  assign pop      = (count_q != '0);

  // The mem entry is older, so the ALU entry lands one slot behind it.
  assign alu_slot = mem_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;

  always_comb begin
    ent_wsel_d = ent_wsel_q;
    ent_wdat_d = ent_wdat_q;
    if (mem_push) begin
      ent_wsel_d[wr_ptr_q] = bus.mem_wsel;
      ent_wdat_d[wr_ptr_q] = bus.mem_wdat;
    end
    if (alu_push) begin
      ent_wsel_d[alu_slot] = bus.alu_wsel;
      ent_wdat_d[alu_slot] = bus.alu_wdat;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(mem_push) + AW'(alu_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_comb begin
    wen_d  = pop;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (pop) begin
      wsel_d = ent_wsel_q[rd_ptr_q];
      wdat_d = ent_wdat_q[rd_ptr_q];
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pend = '0;
    occ  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = AW'(i) - rd_ptr_q;
      if (CW'(occ) < count_q) begin
        pend[ent_wsel_q[i]] = 1'b1;
      end
    end
    if (wen_q) begin
      pend[wsel_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wsel_q[i] <= '0;
        ent_wdat_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wen_q      <= wen_d;
      wsel_q     <= wsel_d;
      wdat_q     <= wdat_d;
      ent_wsel_q <= ent_wsel_d;
      ent_wdat_q <= ent_wdat_d;
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.WEN       = wen_q;
  assign bus.wsel      = wsel_q;
  assign bus.wdat      = wdat_q;
  assign bus.pending   = pend;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_write_buffer.sv
// tb/tb_wb_write_buffer.sv - directed and randomized bench for wb_write_buffer against a queue model
module tb_wb_write_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [36:0] mq [$];
  logic        exp_wen;
  logic [4:0]  exp_wsel;
  logic [31:0] exp_wdat;
  logic [36:0] sent [$];
  logic [36:0] seen [$];
  logic        ma, aa;

  wb_write_buffer_if #(.DEPTH(DEPTH)) bus ();

  wb_write_buffer #(.DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i][36:32]] = 1'b1;
    if (exp_wen) p[exp_wsel] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock: drive requests, check readiness, advance the model, check the write port.
  task automatic step(input logic mv, input logic [4:0] ms, input logic [31:0] md,
                      input logic av, input logic [4:0] as, input logic [31:0] ad,
                      output logic macc, output logic aacc);
    bus.mem_valid = mv;
    bus.mem_wsel  = ms;
    bus.mem_wdat  = md;
    bus.alu_valid = av;
    bus.alu_wsel  = as;
    bus.alu_wdat  = ad;
    #1;
    chk("mem_ready", 32'(bus.mem_ready), 32'(mq.size() <= DEPTH - 1));
    chk("alu_ready", 32'(bus.alu_ready), 32'(mq.size() <= DEPTH - 2));
    macc = mv && (mq.size() <= DEPTH - 1);
    aacc = av && (mq.size() <= DEPTH - 2);
    @(posedge clk);
    if (mq.size() > 0) begin
      logic [36:0] e;
      e = mq.pop_front();
      exp_wen  = 1'b1;
      exp_wsel = e[36:32];
      exp_wdat = e[31:0];
    end else begin
      exp_wen = 1'b0;
    end
    if (macc && ms != 5'd0) begin
      mq.push_back({ms, md});
      sent.push_back({ms, md});
    end
    if (aacc && as != 5'd0) begin
      mq.push_back({as, ad});
      sent.push_back({as, ad});
    end
    #1;
    chk("WEN", 32'(bus.WEN), 32'(exp_wen));
    chk("wsel", 32'(bus.wsel), 32'(exp_wsel));
    chk("wdat", bus.wdat, exp_wdat);
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("pending", bus.pending, model_pending());
    if (bus.WEN) seen.push_back({bus.wsel, bus.wdat});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ma, aa);
  endtask

  initial begin
    logic        mv, av;
    logic [4:0]  ms, as;
    logic [31:0] md, ad;
    logic [4:0]  nxt;

    n_cmp = 0;
    n_err = 0;
    exp_wen = 1'b0;
    exp_wsel = '0;
    exp_wdat = '0;
    rst_n = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_wsel = '0; bus.mem_wdat = '0;
    bus.alu_valid = 1'b0; bus.alu_wsel = '0; bus.alu_wdat = '0;

    #2;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wen", 32'(bus.WEN), 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ALU write r5.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, ma, aa);
    chk("single_pend_c1", 32'(bus.pending[5]), 32'd1);
    chk("single_wen_c1", 32'(bus.WEN), 32'd0);
    idle(1);
    chk("single_wen_c2", 32'(bus.WEN), 32'd1);
    chk("single_wsel_c2", 32'(bus.wsel), 32'd5);
    chk("single_wdat_c2", bus.wdat, 32'hDEADBEEF);
    chk("single_pend_c2", 32'(bus.pending[5]), 32'd1);
    idle(1);
    chk("single_pend_c3", 32'(bus.pending[5]), 32'd0);

    // Same-cycle mem and ALU writes to r3: mem first.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, ma, aa);
    chk("dual_accept", 32'({ma, aa}), 32'd3);
    idle(1);
    chk("dual_first", bus.wdat, 32'h11);
    idle(1);
    chk("dual_second", bus.wdat, 32'h22);
    chk("dual_pend_live", 32'(bus.pending[3]), 32'd1);
    idle(1);
    chk("dual_pend_clear", 32'(bus.pending[3]), 32'd0);

    // r0 from both producers is accepted and dropped.
    step(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77, ma, aa);
    chk("r0_accept", 32'({ma, aa}), 32'd3);
    chk("r0_count", 32'(bus.count), 32'd0);
    idle(2);
    chk("r0_wen", 32'(bus.WEN), 32'd0);

    // Both producers every cycle with distinct registers; requests held until accepted.
    nxt = 5'd1;
    ms = nxt; nxt = nxt + 5'd1; md = $urandom;
    as = nxt; nxt = nxt + 5'd1; ad = $urandom;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, ms, md, 1'b1, as, ad, ma, aa);
      if (ma) begin ms = nxt; nxt = (nxt == 5'd31) ? 5'd1 : nxt + 5'd1; md = $urandom; end
      if (aa) begin as = nxt; nxt = (nxt == 5'd31) ? 5'd1 : nxt + 5'd1; ad = $urandom; end
    end
    chk("sat_count_ge3", 32'(bus.count >= 3), 32'd1);
    chk("sat_alu_ready", 32'(bus.alu_ready), 32'd0);

    // Asynchronous reset with entries queued.
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_wen", 32'(bus.WEN), 32'd0);
    chk("arst_pending", bus.pending, 32'd0);
    chk("arst_wsel", 32'(bus.wsel), 32'd0);
    mq.delete();
    exp_wen = 1'b0;
    exp_wsel = '0;
    exp_wdat = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    chk("arst_no_stale", 32'(bus.WEN), 32'd0);

    // Pointer wrap: single ALU writes every other cycle, ordering checked end to end.
    sent.delete();
    seen.delete();
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom_range(1, 31)), $urandom, ma, aa);
      idle(1);
    end
    idle(2);
    chk("wrap_len", 32'(seen.size()), 32'(2 * DEPTH + 1));
    for (int i = 0; i < 2 * DEPTH + 1 && i < seen.size(); i++) begin
      chk("wrap_order", {27'd0, seen[i][36:32]} ^ seen[i][31:0], {27'd0, sent[i][36:32]} ^ sent[i][31:0]);
      chk("wrap_data", seen[i][31:0], sent[i][31:0]);
    end

    // Random traffic, producers hold until accepted.
    mv = 1'b0; av = 1'b0; ms = '0; as = '0; md = '0; ad = '0;
    for (int i = 0; i < 300; i++) begin
      if (!mv && ($urandom_range(0, 3) != 0)) begin
        mv = 1'b1; ms = 5'($urandom_range(0, 31)); md = $urandom;
      end
      if (!av && ($urandom_range(0, 3) != 0)) begin
        av = 1'b1; as = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      step(mv, ms, md, av, as, ad, ma, aa);
      if (ma) mv = 1'b0;
      if (aa) av = 1'b0;
    end
    idle(DEPTH + 2);
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_pending", bus.pending, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
